sigmoid_act: RTL and testbench



---
 rtl/sigmoid_pkg.sv | 36 +++
 rtl/sigmoid_lut.sv | 26 ++
 rtl/sigmoid_act.sv | 93 +++++++++
 tb/tb_sigmoid_act.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sigmoid_pkg.sv
// Shared constants for the sigmoid activation unit: widths, the index scaling
// and the 61-entry sigmoid table for x >= 0.
package sigmoid_pkg;

    localparam int IN_W      = 16;
    localparam int OUT_W     = 8;
    localparam int LUT_DEPTH = 61;
    localparam int LUT_MAX   = 60;
    localparam int IDX_W     = 6;

    // idx = (|x| * 10 + 128) >> 8 maps Q7.8 onto 0.1 steps, rounded to nearest
    localparam int CALC_W    = 19;
    localparam int IDX_MUL   = 10;
    localparam int IDX_RND   = 128;
    localparam int IDX_SHIFT = 8;
    localparam int RAW_W     = CALC_W - IDX_SHIFT;

    localparam logic [OUT_W-1:0] RESET_Q = 8'h80;

    localparam logic [OUT_W-1:0] TABLE [0:LUT_DEPTH-1] = '{
        8'h80, 8'h86, 8'h8D, 8'h93, 8'h99, 8'h9F, 8'hA5, 8'hAB, 8'hB1, 8'hB6,
        8'hBB, 8'hC0, 8'hC5, 8'hC9, 8'hCD, 8'hD1, 8'hD5, 8'hD8, 8'hDC, 8'hDF,
        8'hE1, 8'hE4, 8'hE6, 8'hE9, 8'hEB, 8'hED, 8'hEE, 8'hF0, 8'hF1, 8'hF3,
        8'hF4, 8'hF5, 8'hF6, 8'hF7, 8'hF8, 8'hF8, 8'hF9, 8'hFA, 8'hFA, 8'hFB,
        8'hFB, 8'hFC, 8'hFC, 8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'hFE, 8'hFE, 8'hFE,
        8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
        8'hFF
    };

    function automatic logic [RAW_W-1:0] scale_index(input logic [IN_W-1:0] mag);
        logic [CALC_W-1:0] scaled;
        scaled = CALC_W'(mag) * CALC_W'(IDX_MUL) + CALC_W'(IDX_RND);
        return scaled[CALC_W-1:IDX_SHIFT];
    endfunction

endpackage

// File: rtl/sigmoid_lut.sv
// Synchronous-read sigmoid table; the output register only loads when en is high.
module sigmoid_lut
    import sigmoid_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [IDX_W-1:0] idx,
    output logic [OUT_W-1:0] q
);

    logic [IDX_W-1:0] idx_safe;

    assign idx_safe = (idx > IDX_W'(LUT_MAX)) ? IDX_W'(LUT_MAX) : idx;

    // NOTE: the table is a constant ROM and needs no reset; only the read register is reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst) begin
            q <= RESET_Q;
        end else if (en) begin
            q <= TABLE[idx_safe];
        end
    end

endmodule

// File: rtl/sigmoid_act.sv
// Three-stage streaming sigmoid: index compute, table lookup, sign reconstruction
// via sigma(-x) = 1 - sigma(x). One global stall enable shared by all stages.
module sigmoid_act
    import sigmoid_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_y,
    output logic             out_sat
);

    logic             adv;
    logic [IN_W-1:0]  mag;
    logic [RAW_W-1:0] idx_raw;
    logic             idx_sat;
    logic [IDX_W-1:0] idx_clamped;

    logic             s1_valid;
    logic             s1_sign;
    logic             s1_sat;
    logic [IDX_W-1:0] s1_idx;

    logic             s2_valid;
    logic             s2_sign;
    logic             s2_sat;
    logic [OUT_W-1:0] lut_q;
    logic [OUT_W-1:0] y_next;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch can be inferred.
        mag         = in_x;
        idx_raw     = '0;
        idx_sat     = 1'b0;
        idx_clamped = '0;
        if (in_x[IN_W-1]) begin
            mag = ~in_x + IN_W'(1);
        end
        idx_raw     = scale_index(mag);
        idx_sat     = idx_raw > RAW_W'(LUT_MAX);
        idx_clamped = idx_sat ? IDX_W'(LUT_MAX) : idx_raw[IDX_W-1:0];
    end

    sigmoid_lut u_lut (
        .clk (clk),
        .rst (rst),
        .en  (adv),
        .idx (s1_idx),
        .q   (lut_q)
    );

    // Two's complement of lut_q is 256 - lut_q; lut_q >= 0x80 keeps it in range
    always_comb begin
        y_next = lut_q;
        if (s2_sign) begin
            y_next = ~lut_q + OUT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_sat    <= 1'b0;
            s1_idx    <= '0;
            s2_valid  <= 1'b0;
            s2_sign   <= 1'b0;
            s2_sat    <= 1'b0;
            out_valid <= 1'b0;
            out_y     <= '0;
            out_sat   <= 1'b0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s1_sign   <= in_x[IN_W-1];
            s1_sat    <= idx_sat;
            s1_idx    <= idx_clamped;
            s2_valid  <= s1_valid;
            s2_sign   <= s1_sign;
            s2_sat    <= s1_sat;
            out_valid <= s2_valid;
            out_y     <= y_next;
            out_sat   <= s2_sat;
        end
    end

endmodule

// File: tb/tb_sigmoid_act.sv
// Self-checking bench for sigmoid_act: directed spec points, backpressure, mid-stream
// reset and an exhaustive randomized-ready sweep against a behavioural model.
module tb_sigmoid_act;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_y;
    logic        out_sat;

    int tests  = 0;
    int errors = 0;
    int cyc    = 0;
    int ready_mode = 0;  // 0: always ready, 1: random, 2: scripted stall window, 3: never ready
    int bp_lo  = 0;
    logic last_in_fire;
    string cur_tag = "stream";
    logic [8:0] sb [$];

    logic [7:0] tbl [0:60] = '{
        8'h80, 8'h86, 8'h8D, 8'h93, 8'h99, 8'h9F, 8'hA5, 8'hAB, 8'hB1, 8'hB6,
        8'hBB, 8'hC0, 8'hC5, 8'hC9, 8'hCD, 8'hD1, 8'hD5, 8'hD8, 8'hDC, 8'hDF,
        8'hE1, 8'hE4, 8'hE6, 8'hE9, 8'hEB, 8'hED, 8'hEE, 8'hF0, 8'hF1, 8'hF3,
        8'hF4, 8'hF5, 8'hF6, 8'hF7, 8'hF8, 8'hF8, 8'hF9, 8'hFA, 8'hFA, 8'hFB,
        8'hFB, 8'hFC, 8'hFC, 8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'hFE, 8'hFE, 8'hFE,
        8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
        8'hFF
    };

    sigmoid_act dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {sat, y}: magnitude, rounded 0.1-step index, clamp, then symmetry
    function automatic logic [8:0] model(input logic [15:0] x);
        int  a;
        int  idx;
        int  y;
        bit  sat;
        a   = x[15] ? 65536 - int'(x) : int'(x);
        idx = (a * 10 + 128) / 256;
        sat = idx > 60;
        if (sat) idx = 60;
        y = x[15] ? 256 - int'(tbl[idx]) : int'(tbl[idx]);
        return {sat, 8'(y)};
    endfunction

    // One clock: pick out_ready, sample handshakes pre-edge, update scoreboard, return at negedge
    task automatic step();
        logic       in_fire;
        logic       out_fire;
        logic       stalled;
        logic [7:0] y_b;
        logic       sat_b;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(15) != 0);
            2:       out_ready = !(cyc >= bp_lo && cyc < bp_lo + 5);
            default: out_ready = 1'b0;
        endcase
        #1;
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        stalled  = out_valid && !out_ready;
        y_b      = out_y;
        sat_b    = out_sat;
        if (!rst) check("in_ready", in_ready, !out_valid || out_ready);
        @(posedge clk);
        cyc++;
        last_in_fire = in_fire && !rst;
        if (rst) begin
            sb.delete();
        end else begin
            if (out_fire) begin
                check({cur_tag, "_expected_pending"}, sb.size() > 0, 1);
                if (sb.size() > 0) check(cur_tag, {sat_b, y_b}, sb.pop_front());
            end
            if (in_fire) sb.push_back(model(in_x));
        end
        @(negedge clk);
        if (stalled && !rst) check("stall_hold", {out_valid, out_sat, out_y}, {1'b1, sat_b, y_b});
    endtask

    task automatic send(input logic [15:0] x);
        int n;
        in_valid = 1'b1;
        in_x     = x;
        n = 0;
        do begin
            step();
            n++;
        end while (!last_in_fire && n < 200);
        if (!last_in_fire) check("accept_timeout", n, 0);
    endtask

    task automatic drain();
        int n;
        in_valid   = 1'b0;
        ready_mode = 0;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            step();
            n++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic single(input logic [15:0] x, input logic [7:0] ey, input logic esat,
                          input string tag);
        int lat;
        ready_mode = 0;
        in_valid   = 1'b1;
        in_x       = x;
        step();
        check({tag, "_accept"}, last_in_fire, 1);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, lat, 3);
        check({tag, "_y"}, out_y, ey);
        check({tag, "_sat"}, out_sat, esat);
        step();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        out_ready = 1'b1;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        check("reset_valid", out_valid, 0);
        check("reset_y", out_y, 8'h00);
        check("reset_sat", out_sat, 0);
        check("reset_in_ready", in_ready, 1);

        single(16'h0000, 8'h80, 1'b0, "zero");
        single(16'h0100, 8'hBB, 1'b0, "plus_one");
        single(16'hFF00, 8'h45, 1'b0, "minus_one");
        single(16'h000C, 8'h80, 1'b0, "round_12");
        single(16'h000D, 8'h86, 1'b0, "round_13");
        single(16'hFFF3, 8'h7A, 1'b0, "round_neg13");
        single(16'h0600, 8'hFF, 1'b0, "edge_6p0");
        single(16'h060D, 8'hFF, 1'b1, "edge_idx61");
        single(16'h7FFF, 8'hFF, 1'b1, "sat_pos");
        single(16'h8000, 8'h01, 1'b1, "sat_neg");

        // Backpressure: 20 back-to-back samples with a 5-cycle stall window mid-stream
        cur_tag    = "backpressure";
        bp_lo      = cyc + 8;
        ready_mode = 2;
        for (int i = 0; i < 20; i++) send(16'($urandom));
        drain();

        // Mid-stream reset with three samples in flight
        cur_tag    = "rst_stream";
        ready_mode = 0;
        send(16'h0200);
        send(16'hFE00);
        send(16'h0080);
        in_valid   = 1'b0;
        ready_mode = 3;
        rst        = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_valid", out_valid, 0);
        check("midrst_y", out_y, 8'h00);
        check("midrst_sat", out_sat, 0);
        check("midrst_in_ready", in_ready, 1);
        ready_mode = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("midrst_no_ghost", out_valid, 0);
        end
        single(16'h0100, 8'hBB, 1'b0, "post_rst");

        // Random values with random input gaps and random downstream readiness
        cur_tag    = "random";
        ready_mode = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3) == 0) begin
                in_valid = 1'b0;
                step();
            end
            send(16'($urandom));
        end
        drain();

        // Exhaustive sweep of every input code
        cur_tag    = "sweep";
        ready_mode = 1;
        for (int i = 0; i < 65536; i++) send(16'(i));
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
